// File: rtl/register_dumper_if.sv
// Dump stream carrying one register index/value word per valid/ready handshake.
// No storage here; timing is set entirely by the producer and consumer.
// The producer holds index/data stable while dump_valid is high and dump_ready is low.
interface register_dumper_if;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;

  modport master (
    output dump_valid,
    output dump_index,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_index,
    input  dump_data,
    output dump_ready
  );
endinterface

// File: rtl/register_dumper.sv
// Walks register file indices FIRST_REG..LAST_REG and streams index/value words.
// Latency: start edge -> LOAD; first word valid one edge later; 2 cycles per word at full rate.
// Backpressure: a word is held unchanged until accepted; dump_valid never drops without a handshake.
module register_dumper #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  selector_out,
  input  logic [31:0] value_out,
  register_dumper_if.master dump
);

  // Out-of-range configurations are rejected at elaboration.
  if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_cfg
    $error("register_dumper: need FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST_SEL = 5'(FIRST_REG);
  localparam logic [4:0] LAST_SEL  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t      state;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  sel_q;
  logic        valid_q;
  logic [4:0]  index_q;
  logic [31:0] data_q;

  // Dump sequencer: one register read per LOAD, held in SEND until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 5'd0;
      valid_q <= 1'b0;
      index_q <= 5'd0;
      data_q  <= 32'd0;
    end else begin
      // done is a single-cycle pulse; only the final handshake re-raises it.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_q  <= FIRST_SEL;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          // The register file read is combinational, so value_out matches sel_q now.
          data_q  <= value_out;
          index_q <= sel_q;
          valid_q <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (valid_q && dump.dump_ready) begin
            valid_q <= 1'b0;
            if (index_q == LAST_SEL) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              // Never wraps: the walk stops at LAST_SEL <= 31.
              sel_q <= sel_q + 5'd1;
              state <= LOAD;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign selector_out    = sel_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_index = index_q;
  assign dump.dump_data  = data_q;

endmodule
